// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-access control encoding and the
// state encoding of the memory-access sequencer.
package lc3_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Access type presented on M_Control
    typedef enum logic [1:0] {
        MC_LD  = 2'd0,   // LD / LDR : direct read
        MC_LDI = 2'd1,   // LDI      : indirect read
        MC_ST  = 2'd2,   // ST / STR : direct write
        MC_STI = 2'd3    // STI      : indirect write
    } mctrl_e;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_IND      = 3'd1,
        S_IND_WAIT = 3'd2,
        S_RD       = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_WR       = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    // Indirect accesses first fetch the real address from memory
    function automatic logic is_indirect(input mctrl_e c);
        return (c == MC_LDI) || (c == MC_STI);
    endfunction

endpackage

// File: rtl/mem_access.sv
// LC-3 data-memory access sequencer. Accepts one load/store request at a
// time, performs the optional indirection read, then the data read or
// write, and pulses done when the access is complete.
module mem_access
    import lc3_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          M_Control,
    input  logic [ADDR_W-1:0]   M_Addr,
    input  logic [DATA_W-1:0]   M_Data,
    input  logic [DATA_W-1:0]   Dmem_dout,
    output logic [ADDR_W-1:0]   Dmem_addr,
    output logic [DATA_W-1:0]   Dmem_din,
    output logic                Dmem_rd,
    output logic                Dmem_we,
    output logic [DATA_W-1:0]   memout,
    output logic                busy,
    output logic                done
);

    state_e              r_state;
    mctrl_e              r_ctrl_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_data_q;
    logic [DATA_W-1:0]   r_memout;

    mctrl_e              w_ctrl_in;
    logic                w_rd_state;
    logic                w_we_state;
    logic                w_done_state;

    assign w_ctrl_in = mctrl_e'(M_Control);

    // Sequencer: request capture, indirection, read/write and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ctrl_q <= MC_LD;
            r_addr_q <= '0;
            r_data_q <= '0;
            r_memout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ctrl_q <= w_ctrl_in;
                        r_addr_q <= M_Addr;
                        r_data_q <= M_Data;
                        if (is_indirect(w_ctrl_in))
                            r_state <= S_IND;
                        else if (w_ctrl_in == MC_LD)
                            r_state <= S_RD;
                        else
                            r_state <= S_WR;
                    end
                end
                S_IND:      r_state <= S_IND_WAIT;
                S_IND_WAIT: begin
                    // Pointer fetched from memory becomes the effective address
                    r_addr_q <= Dmem_dout;
                    r_state  <= (r_ctrl_q == MC_LDI) ? S_RD : S_WR;
                end
                S_RD:       r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_memout <= Dmem_dout;
                    r_state  <= S_DONE;
                end
                S_WR:       r_state <= S_DONE;
                S_DONE:     r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from state; reset masks them even in the reset cycle
    always_comb begin
        w_rd_state   = (r_state == S_IND) || (r_state == S_RD);
        w_we_state   = (r_state == S_WR);
        w_done_state = (r_state == S_DONE);
    end

    assign Dmem_rd   = w_rd_state   & ~rst;
    assign Dmem_we   = w_we_state   & ~rst;
    assign done      = w_done_state & ~rst;
    assign busy      = (r_state != S_IDLE);
    assign Dmem_addr = r_addr_q;
    assign Dmem_din  = r_data_q;
    assign memout    = r_memout;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a 1-cycle synchronous-read memory.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  M_Control;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] Dmem_dout;
    logic [15:0] Dmem_addr;
    logic [15:0] Dmem_din;
    logic        Dmem_rd;
    logic        Dmem_we;
    logic [15:0] memout;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [15:0] mem [0:65535];
    logic [15:0] rd_q[$];
    logic [15:0] we_q[$];
    logic [15:0] wd_q[$];

    mem_access dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .M_Control (M_Control),
        .M_Addr    (M_Addr),
        .M_Data    (M_Data),
        .Dmem_dout (Dmem_dout),
        .Dmem_addr (Dmem_addr),
        .Dmem_din  (Dmem_din),
        .Dmem_rd   (Dmem_rd),
        .Dmem_we   (Dmem_we),
        .memout    (memout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory model and strobe monitor
    always @(posedge clk) begin
        if (Dmem_rd) begin
            Dmem_dout <= mem[Dmem_addr];
            rd_q.push_back(Dmem_addr);
        end
        if (Dmem_we) begin
            mem[Dmem_addr] <= Dmem_din;
            we_q.push_back(Dmem_addr);
            wd_q.push_back(Dmem_din);
        end
    end

    task automatic clear_logs();
        rd_q.delete();
        we_q.delete();
        wd_q.delete();
    endtask

    // Issue one request; returns done latency, first Dmem_we cycle and busy in cycle 1
    task automatic run_access(input logic [1:0] c, input logic [15:0] a,
                              input logic [15:0] d, output int lat,
                              output int we_k, output logic busy1);
        @(negedge clk);
        start = 1'b1; M_Control = c; M_Addr = a; M_Data = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; we_k = -1; busy1 = busy;
        for (int k = 1; k <= 12; k++) begin
            if (Dmem_we && we_k < 0) we_k = k;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (Dmem_rd !== 1'b0 || Dmem_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got rd=%b we=%b exp=0", Dmem_rd, Dmem_we); end
        checks++; if (memout !== 16'h0000) begin failures++; $display("FAIL reset_memout got=%h exp=0000", memout); end
        checks++; if (Dmem_addr !== 16'h0000 || Dmem_din !== 16'h0000) begin failures++; $display("FAIL reset_addr_din got=%h/%h exp=0000/0000", Dmem_addr, Dmem_din); end
        rst = 1'b0;
    endtask

    task automatic test_ld();
        int lat, we_k; logic b1;
        clear_logs();
        run_access(2'd0, 16'h3000, 16'h0000, lat, we_k, b1);
        checks++; if (lat != 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL ld_busy got=%b exp=1", b1); end
        checks++; if (rd_q.size() != 1) begin failures++; $display("FAIL ld_rd_count got=%0d exp=1", rd_q.size()); end
        else begin
            checks++; if (rd_q[0] !== 16'h3000) begin failures++; $display("FAIL ld_rd_addr got=%h exp=3000", rd_q[0]); end
        end
        checks++; if (we_q.size() != 0) begin failures++; $display("FAIL ld_we_count got=%0d exp=0", we_q.size()); end
        checks++; if (memout !== 16'h4000) begin failures++; $display("FAIL ld_memout got=%h exp=4000", memout); end
    endtask

    task automatic test_ldi();
        int lat, we_k; logic b1;
        clear_logs();
        run_access(2'd1, 16'h3000, 16'h0000, lat, we_k, b1);
        checks++; if (lat != 5) begin failures++; $display("FAIL ldi_latency got=%0d exp=5", lat); end
        checks++; if (rd_q.size() != 2) begin failures++; $display("FAIL ldi_rd_count got=%0d exp=2", rd_q.size()); end
        else begin
            checks++; if (rd_q[0] !== 16'h3000 || rd_q[1] !== 16'h4000) begin failures++; $display("FAIL ldi_rd_addr got=%h,%h exp=3000,4000", rd_q[0], rd_q[1]); end
        end
        checks++; if (memout !== 16'hBEEF) begin failures++; $display("FAIL ldi_memout got=%h exp=beef", memout); end
    endtask

    task automatic test_st();
        int lat, we_k; logic b1;
        clear_logs();
        run_access(2'd2, 16'h3100, 16'h1234, lat, we_k, b1);
        checks++; if (lat != 2) begin failures++; $display("FAIL st_latency got=%0d exp=2", lat); end
        checks++; if (we_k != 1) begin failures++; $display("FAIL st_we_cycle got=%0d exp=1", we_k); end
        checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL st_rd_count got=%0d exp=0", rd_q.size()); end
        checks++; if (we_q.size() != 1) begin failures++; $display("FAIL st_we_count got=%0d exp=1", we_q.size()); end
        else begin
            checks++; if (we_q[0] !== 16'h3100 || wd_q[0] !== 16'h1234) begin failures++; $display("FAIL st_we_addr_din got=%h/%h exp=3100/1234", we_q[0], wd_q[0]); end
        end
        checks++; if (memout !== 16'hBEEF) begin failures++; $display("FAIL st_memout_hold got=%h exp=beef", memout); end
        checks++; if (mem[16'h3100] !== 16'h1234) begin failures++; $display("FAIL st_mem got=%h exp=1234", mem[16'h3100]); end
    endtask

    task automatic test_sti();
        int lat, we_k; logic b1;
        clear_logs();
        run_access(2'd3, 16'h3000, 16'h5555, lat, we_k, b1);
        checks++; if (lat != 4) begin failures++; $display("FAIL sti_latency got=%0d exp=4", lat); end
        checks++; if (we_k != 3) begin failures++; $display("FAIL sti_we_cycle got=%0d exp=3", we_k); end
        checks++; if (rd_q.size() != 1) begin failures++; $display("FAIL sti_rd_count got=%0d exp=1", rd_q.size()); end
        else begin
            checks++; if (rd_q[0] !== 16'h3000) begin failures++; $display("FAIL sti_rd_addr got=%h exp=3000", rd_q[0]); end
        end
        checks++; if (we_q.size() != 1) begin failures++; $display("FAIL sti_we_count got=%0d exp=1", we_q.size()); end
        else begin
            checks++; if (we_q[0] !== 16'h4000 || wd_q[0] !== 16'h5555) begin failures++; $display("FAIL sti_we_addr_din got=%h/%h exp=4000/5555", we_q[0], wd_q[0]); end
        end
        checks++; if (mem[16'h4000] !== 16'h5555) begin failures++; $display("FAIL sti_mem got=%h exp=5555", mem[16'h4000]); end
        checks++; if (memout !== 16'hBEEF) begin failures++; $display("FAIL sti_memout_hold got=%h exp=beef", memout); end
    endtask

    task automatic test_addr_ffff();
        int lat, we_k; logic b1;
        clear_logs();
        run_access(2'd0, 16'hFFFF, 16'h0000, lat, we_k, b1);
        checks++; if (lat != 3) begin failures++; $display("FAIL ffff_latency got=%0d exp=3", lat); end
        checks++; if (rd_q.size() != 1) begin failures++; $display("FAIL ffff_rd_count got=%0d exp=1", rd_q.size()); end
        else begin
            checks++; if (rd_q[0] !== 16'hFFFF) begin failures++; $display("FAIL ffff_rd_addr got=%h exp=ffff", rd_q[0]); end
        end
        checks++; if (memout !== 16'hA5A5) begin failures++; $display("FAIL ffff_memout got=%h exp=a5a5", memout); end
    endtask

    task automatic test_back_to_back();
        int exp_busy [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
        int exp_done [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        clear_logs();
        @(negedge clk);
        start = 1'b1; M_Control = 2'd0; M_Addr = 16'h3000; M_Data = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        M_Control = 2'd2; M_Addr = 16'h3100; M_Data = 16'h7777;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (int'(busy) != exp_busy[k-1] || int'(done) != exp_done[k-1]) begin
                failures++;
                $display("FAIL b2b_cycle%0d got busy=%b done=%b exp busy=%0d done=%0d", k, busy, done, exp_busy[k-1], exp_done[k-1]);
            end
            if (k == 5) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (rd_q.size() != 1) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=1", rd_q.size()); end
        checks++; if (we_q.size() != 1) begin failures++; $display("FAIL b2b_we_count got=%0d exp=1", we_q.size()); end
        else begin
            checks++; if (we_q[0] !== 16'h3100 || wd_q[0] !== 16'h7777) begin failures++; $display("FAIL b2b_we_addr_din got=%h/%h exp=3100/7777", we_q[0], wd_q[0]); end
        end
        checks++; if (memout !== 16'h4000) begin failures++; $display("FAIL b2b_memout got=%h exp=4000", memout); end
    endtask

    task automatic test_reset_strobe();
        clear_logs();
        @(negedge clk);
        start = 1'b1; M_Control = 2'd1; M_Addr = 16'h3000; M_Data = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (Dmem_rd !== 1'b1) begin failures++; $display("FAIL rststb_ind_rd got=%b exp=1", Dmem_rd); end
        rst = 1'b1;
        #1;
        checks++; if (Dmem_rd !== 1'b0) begin failures++; $display("FAIL rststb_masked got=%b exp=0", Dmem_rd); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL rststb_rd_count got=%0d exp=0", rd_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rststb_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat, we_k; logic b1;
        clear_logs();
        @(negedge clk);
        start = 1'b1; M_Control = 2'd3; M_Addr = 16'h3000; M_Data = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (Dmem_we !== 1'b0 || Dmem_rd !== 1'b0) begin failures++; $display("FAIL abort_strobes got rd=%b we=%b exp=0", Dmem_rd, Dmem_we); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_state got busy=%b done=%b exp=0", busy, done); end
        checks++; if (memout !== 16'h0000) begin failures++; $display("FAIL abort_memout got=%h exp=0000", memout); end
        repeat (6) @(negedge clk);
        checks++; if (we_q.size() != 0) begin failures++; $display("FAIL abort_we_count got=%0d exp=0", we_q.size()); end
        checks++; if (mem[16'h4000] !== 16'h5555) begin failures++; $display("FAIL abort_mem got=%h exp=5555", mem[16'h4000]); end
        run_access(2'd0, 16'h3000, 16'h0000, lat, we_k, b1);
        checks++; if (lat != 3) begin failures++; $display("FAIL abort_ld_latency got=%0d exp=3", lat); end
        checks++; if (memout !== 16'h4000) begin failures++; $display("FAIL abort_ld_memout got=%h exp=4000", memout); end
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst = 1'b1; start = 1'b0;
        M_Control = 2'd0; M_Addr = 16'h0000; M_Data = 16'h0000;
        Dmem_dout = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'h4000;
        mem[16'h4000] = 16'hBEEF;
        mem[16'hFFFF] = 16'hA5A5;

        test_reset();
        test_ld();
        test_ldi();
        test_st();
        test_sti();
        test_addr_ffff();
        test_back_to_back();
        test_reset_strobe();
        test_reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset. The ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  access request; sampled only in IDLE.
REQ-005 M_Control  input  2  access type: 0 = LD/LDR (direct read), 1 = LDI (indirect read), 2 = ST/STR (direct write), 3 = STI (indirect write).
REQ-006 M_Addr  input  16  effective address; sampled with start.
REQ-007 M_Data  input  16  store data (VSR2 value); sampled with start.
REQ-008 Dmem_dout  input  16  data-memory read data; valid the cycle after Dmem_rd.
REQ-009 Dmem_addr  output  16  data-memory address.
REQ-010 Dmem_din  output  16  data-memory write data.
REQ-011 Dmem_rd  output  1  data-memory read strobe.
REQ-012 Dmem_we  output  1  data-memory write strobe.
REQ-013 memout  output  16  last loaded value, presented to writeback.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, IND, IND_WAIT, RD, RD_WAIT, WR and DONE; outputs depend only on state and internal registers.
REQ-017 In IDLE with start=1: SHALL latch ctrl_q, addr_q and data_q, then go to IND if ctrl is 1 or 3, RD if ctrl is 0, and WR if ctrl is 2.
REQ-018 IND: SHALL drive Dmem_rd=1 and Dmem_addr=addr_q, then go to IND_WAIT.
REQ-019 IND_WAIT: SHALL load addr_q from Dmem_dout, then go to RD if ctrl_q=1, otherwise WR.
REQ-020 RD: SHALL drive Dmem_rd=1 and Dmem_addr=addr_q, then go to RD_WAIT.
REQ-021 RD_WAIT: SHALL load memout from Dmem_dout, then go to DONE.
REQ-022 WR: SHALL drive Dmem_we=1, Dmem_addr=addr_q and Dmem_din=data_q for exactly one cycle, then go to DONE.
REQ-023 DONE: SHALL drive done=1 for one cycle, then go to IDLE.
REQ-024 Latency from the start-accept edge to the done cycle SHALL be: LD 3 cycles, LDI 5, ST 2, STI 4.
REQ-025 start SHALL be ignored in every state other than IDLE, including DONE. A start held continuously yields back-to-back accesses, each separated by one IDLE cycle.
REQ-026 memout SHALL hold its value until the next RD_WAIT; writes SHALL NOT change it.
REQ-027 Outside IND, RD and WR: Dmem_rd=0 and Dmem_we=0. Dmem_addr and Dmem_din SHALL still reflect addr_q and data_q.
REQ-028 Exactly one Dmem_rd cycle per LD, two per LDI, one per STI, and zero per ST.
REQ-029 Address arithmetic SHALL be none: addresses pass through unmodified at full 16 bits, and 0xFFFF is legal.

Reset
REQ-030 While rst=1: Dmem_rd, Dmem_we and done SHALL be forced to 0 combinationally, so a strobe is suppressed even during the reset cycle.
REQ-031 After the reset edge: state=IDLE, and memout, addr_q, data_q and ctrl_q all equal 0. busy=0.
REQ-032 Reset mid-operation SHALL abort the access. No pending read or write SHALL be issued afterwards.

Structure
REQ-033 The M_Control encoding enum and the FSM state enum SHALL reside in the shared package lc3_pkg.
REQ-034 The block SHALL be a single module with no sub-modules. Data memory is external; the bench provides a 1-cycle synchronous-read memory model.

Verification
(Bench memory preload: mem[0x3000]=0x4000, mem[0x4000]=0xBEEF.)
REQ-035 LD: ctrl=0, addr=0x3000 -> one Dmem_rd at 0x3000; done 3 cycles after accept; memout=0x4000.
REQ-036 LDI: ctrl=1, addr=0x3000 -> Dmem_rd at 0x3000, then Dmem_rd at 0x4000; done at +5; memout=0xBEEF.
REQ-037 ST: ctrl=2, addr=0x3100, data=0x1234 -> Dmem_we for one cycle at +1 with addr 0x3100 and din 0x1234; done at +2; memout unchanged; mem[0x3100]=0x1234.
REQ-038 STI: ctrl=3, addr=0x3000, data=0x5555 -> Dmem_rd at 0x3000, then Dmem_we at 0x4000 with din 0x5555; done at +4.
REQ-039 start held high through an LD followed by an ST -> second access is accepted only in the IDLE cycle after DONE; start pulses during busy are dropped; no extra strobes.
REQ-040 rst asserted in IND_WAIT of an STI -> Dmem_we never asserts; next cycle busy=0, done=0, memout=0x0000; a subsequent LD completes normally.
